// File: rtl/kamus_mem_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter onto a single
// request/grant/rvalid memory port. Only one memory transaction is in
// flight at a time; LSU is favoured on contention, with a starvation
// counter that hands IF one grant after STARVE_LIMIT consecutive LSU wins.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | arbitrate and drive mem_req_o; a driven, ungranted winner
//            | is locked until mem_gnt_i
// ST_OUT_IF  | fetch granted, waiting for its mem_rvalid_i
// ST_OUT_LSU | load/store granted, waiting for its mem_rvalid_i
module kamus_mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [3:0]  lsu_be_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_gnt_o,
   output logic        lsu_rvalid_o,
   output logic [31:0] lsu_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_OUT_IF  = 2'd1;
   localparam logic [1:0] ST_OUT_LSU = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          lock_q, lock_d;
   logic          lock_lsu_q, lock_lsu_d;
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic          drop_q, drop_d;
   logic          store_q, store_d;

   logic if_lock_rel;
   logic lock_eff;
   logic starved;
   logic sel_vld;
   logic sel_lsu;
   logic rsp_if;
   logic rsp_lsu;

   // A locked IF request may only be withdrawn under flush; that releases
   // the lock in the same cycle so LSU can be presented immediately.
   assign if_lock_rel = lock_q & ~lock_lsu_q & flush_i & ~if_req_i;
   assign lock_eff    = lock_q & ~if_lock_rel;
   assign starved     = (starve_cnt_q == CW'(STARVE_LIMIT));

   // Winner selection: a held lock overrides fresh arbitration.
   always_comb begin
      sel_vld = 1'b0;
      sel_lsu = 1'b0;
      if (state_q == ST_IDLE) begin
         if (lock_eff) begin
            sel_vld = 1'b1;
            sel_lsu = lock_lsu_q;
         end else if (lsu_req_i && !(if_req_i && starved)) begin
            sel_vld = 1'b1;
            sel_lsu = 1'b1;
         end else if (if_req_i) begin
            sel_vld = 1'b1;
            sel_lsu = 1'b0;
         end
      end
   end

   assign rsp_if  = (state_q == ST_OUT_IF)  & mem_rvalid_i;
   assign rsp_lsu = (state_q == ST_OUT_LSU) & mem_rvalid_i;

   // Output drive; everything is forced low while reset is asserted.
   always_comb begin
      mem_req_o    = ~rst_i & sel_vld;
      mem_we_o     = ~rst_i & sel_vld & sel_lsu & lsu_we_i;
      mem_be_o     = 4'h0;
      mem_addr_o   = 32'h0;
      mem_wdata_o  = 32'h0;
      if (!rst_i && sel_vld) begin
         mem_be_o    = sel_lsu ? lsu_be_i   : 4'hF;
         mem_addr_o  = sel_lsu ? lsu_addr_i : if_addr_i;
         mem_wdata_o = sel_lsu ? lsu_wdata_i : 32'h0;
      end
      if_gnt_o     = ~rst_i & sel_vld & ~sel_lsu & mem_gnt_i;
      lsu_gnt_o    = ~rst_i & sel_vld &  sel_lsu & mem_gnt_i;
      if_rvalid_o  = ~rst_i & rsp_if & ~drop_q & ~flush_i;
      lsu_rvalid_o = ~rst_i & rsp_lsu;
      if_rdata_o   = if_rvalid_o ? mem_rdata_i : 32'h0;
      lsu_rdata_o  = (lsu_rvalid_o && !store_q) ? mem_rdata_i : 32'h0;
   end

   // Next-state logic for the FSM, lock, starvation counter and drop flag.
   always_comb begin
      state_d      = state_q;
      lock_d       = lock_q;
      lock_lsu_d   = lock_lsu_q;
      starve_cnt_d = starve_cnt_q;
      drop_d       = drop_q;
      store_d      = store_q;
      case (state_q)
         ST_IDLE: begin
            lock_d     = sel_vld & ~mem_gnt_i;
            lock_lsu_d = sel_lsu;
            if (sel_vld && mem_gnt_i) begin
               if (sel_lsu) begin
                  state_d = ST_OUT_LSU;
                  store_d = lsu_we_i;
                  if (if_req_i && !starved) begin
                     starve_cnt_d = starve_cnt_q + CW'(1);
                  end
               end else begin
                  state_d      = ST_OUT_IF;
                  starve_cnt_d = '0;
                  drop_d       = flush_i;
               end
            end
         end
         ST_OUT_IF: begin
            lock_d = 1'b0;
            if (flush_i) begin
               drop_d = 1'b1;
            end
            if (mem_rvalid_i) begin
               state_d = ST_IDLE;
               drop_d  = 1'b0;
            end
         end
         ST_OUT_LSU: begin
            lock_d = 1'b0;
            if (mem_rvalid_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            lock_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         lock_q       <= 1'b0;
         lock_lsu_q   <= 1'b0;
         starve_cnt_q <= '0;
         drop_q       <= 1'b0;
         store_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lock_q       <= lock_d;
         lock_lsu_q   <= lock_lsu_d;
         starve_cnt_q <= starve_cnt_d;
         drop_q       <= drop_d;
         store_q      <= store_d;
      end
   end

endmodule

// File: tb/tb_kamus_mem_arbiter.sv
// Scoreboard bench for kamus_mem_arbiter: expected responses are queued
// as memory responses are driven and compared when an rvalid_o appears.
module tb_kamus_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i, flush_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        lsu_req_i, lsu_we_i;
   logic [3:0]  lsu_be_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic        lsu_gnt_o, lsu_rvalid_o;
   logic [31:0] lsu_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   typedef struct packed {
      logic        is_lsu;
      logic [31:0] data;
   } rsp_t;

   rsp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   sm     = 0;

   kamus_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
      .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_rsp(input logic is_lsu, input logic [31:0] d);
      rsp_t r;
      r.is_lsu = is_lsu;
      r.data   = d;
      sb_q.push_back(r);
   endtask

   // Response monitor: every rvalid_o must match the head of the scoreboard.
   always @(negedge clk_i) begin
      if (if_rvalid_o || lsu_rvalid_o) begin
         if (sb_q.size() == 0) begin
            chk("unexp_rvalid", {if_rvalid_o, lsu_rvalid_o}, 0);
         end else begin
            rsp_t e;
            e = sb_q.pop_front();
            chk("rsp_port", {if_rvalid_o, lsu_rvalid_o}, {~e.is_lsu, e.is_lsu});
            chk("rsp_data", lsu_rvalid_o ? lsu_rdata_o : if_rdata_o, e.data);
         end
      end
   end

   task automatic fetch_if(input logic [31:0] a, input logic [31:0] d,
                           input bit fl_out, input bit fl_rsp);
      if_req_i = 1'b1; if_addr_i = a; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("if_gnt", if_gnt_o, 1);
      chk("if_addr", mem_addr_o, a);
      chk("if_be_we", {mem_be_o, mem_we_o}, {4'hF, 1'b0});
      tick();
      if_req_i = 1'b0; mem_gnt_i = 1'b0; flush_i = fl_out;
      @(negedge clk_i);
      chk("out_if_req", {mem_req_o, if_gnt_o, lsu_gnt_o, if_rdata_o}, 0);
      tick();
      flush_i = fl_rsp; mem_rvalid_i = 1'b1; mem_rdata_i = d;
      if (!(fl_out || fl_rsp)) expect_rsp(1'b0, d);
      @(negedge clk_i);
      chk("if_rvalid", if_rvalid_o, !(fl_out || fl_rsp));
      tick();
      mem_rvalid_i = 1'b0; flush_i = 1'b0; mem_rdata_i = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp_lsu;
      rst_i = 1'b1; flush_i = 1'b0;
      if_req_i = 1'b1; if_addr_i = 32'h0;
      lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'hF;
      lsu_addr_i = 32'h10; lsu_wdata_i = 32'h1234;
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      tick();
      @(negedge clk_i);
      chk("rst_outs", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, if_gnt_o, lsu_gnt_o}, 0);
      tick();
      if_req_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; mem_gnt_i = 1'b0; rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_state", {dut.state_q, dut.starve_cnt_q}, 0);
      tick();

      // Basic IF read
      fetch_if(32'h100, 32'h13, 1'b0, 1'b0);

      // Starvation: IF held, LSU continuous, memory grants everything
      if_req_i = 1'b1; if_addr_i = 32'h200;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF;
      for (int k = 0; k < 5; k++) begin
         lsu_addr_i = 32'h3000 + 32'(4 * k); mem_gnt_i = 1'b1;
         exp_lsu = (sm != 4);
         @(negedge clk_i);
         chk("stv_gnt", {lsu_gnt_o, if_gnt_o}, {exp_lsu, ~exp_lsu});
         if (exp_lsu) sm = sm + 1; else sm = 0;
         tick();
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000 + 32'(k);
         expect_rsp(exp_lsu, 32'h1000 + 32'(k));
         @(negedge clk_i);
         chk("stv_out_req", mem_req_o, 0);
         tick();
         mem_rvalid_i = 1'b0;
      end
      if_req_i = 1'b0; lsu_req_i = 1'b0;
      chk("stv_cnt", dut.starve_cnt_q, sm);

      // Contention: LSU store beats IF
      if_req_i = 1'b1; if_addr_i = 32'h204;
      lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'b0011;
      lsu_addr_i = 32'h2000; lsu_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("cont_mem", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
          {1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF});
      chk("cont_gnt", {lsu_gnt_o, if_gnt_o}, 2'b10);
      tick();
      if_req_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
      expect_rsp(1'b1, 32'h0);
      tick();
      mem_rvalid_i = 1'b0;
      chk("cont_cnt", dut.starve_cnt_q, sm + 1);

      // Lock stability: IF locked while LSU arrives
      if_req_i = 1'b1; if_addr_i = 32'h400; mem_gnt_i = 1'b0;
      @(negedge clk_i);
      chk("lock_c1", {mem_req_o, mem_addr_o}, {1'b1, 32'h400});
      tick();
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h5000; lsu_be_i = 4'hF;
      @(negedge clk_i);
      chk("lock_c2", {mem_req_o, mem_we_o, mem_addr_o, lsu_gnt_o}, {1'b1, 1'b0, 32'h400, 1'b0});
      tick();
      @(negedge clk_i);
      chk("lock_c3", mem_addr_o, 32'h400);
      tick();
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("lock_gnt", {if_gnt_o, lsu_gnt_o, mem_addr_o}, {1'b1, 1'b0, 32'h400});
      tick();
      if_req_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
      expect_rsp(1'b0, 32'h77);
      @(negedge clk_i);
      chk("bubble", {mem_req_o, lsu_gnt_o}, 0);
      tick();
      mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("lsu_after", {lsu_gnt_o, mem_addr_o}, {1'b1, 32'h5000});
      tick();
      lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h88;
      expect_rsp(1'b1, 32'h88);
      tick();
      mem_rvalid_i = 1'b0;
      chk("lock_cnt", dut.starve_cnt_q, 0);

      // Flush while fetch outstanding, flush coincident with response
      fetch_if(32'h600, 32'hABCD0000, 1'b1, 1'b0);
      fetch_if(32'h604, 32'h1234, 1'b0, 1'b0);
      fetch_if(32'h608, 32'h5678, 1'b0, 1'b1);
      fetch_if(32'h60C, 32'h9ABC, 1'b0, 1'b0);

      // Locked IF withdrawn under flush: LSU appears at once
      if_req_i = 1'b1; if_addr_i = 32'h700; mem_gnt_i = 1'b0;
      tick();
      if_req_i = 1'b0; flush_i = 1'b1;
      lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'hF;
      lsu_addr_i = 32'h8000; lsu_wdata_i = 32'hCAFEF00D;
      @(negedge clk_i);
      chk("rel_mem", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b1, 32'h8000});
      tick();
      flush_i = 1'b0; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("rel_gnt", {lsu_gnt_o, if_gnt_o, mem_wdata_o}, {1'b1, 1'b0, 32'hCAFEF00D});
      tick();
      lsu_req_i = 1'b0; lsu_we_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
      expect_rsp(1'b1, 32'h0);
      tick();
      mem_rvalid_i = 1'b0;
      if_req_i = 1'b1; if_addr_i = 32'h710;
      tick();
      if_req_i = 1'b0; flush_i = 1'b1;
      @(negedge clk_i);
      chk("rel_idle", mem_req_o, 0);
      tick();
      flush_i = 1'b0;

      // Stray rvalid in IDLE
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF;
      @(negedge clk_i);
      chk("stray", {if_rvalid_o, lsu_rvalid_o, if_rdata_o, lsu_rdata_o}, 0);
      tick();
      mem_rvalid_i = 1'b0;
      chk("stray_st", dut.state_q, 0);

      // Reset while in OUT_LSU
      if_req_i = 1'b1; if_addr_i = 32'h900;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h9000; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("pre_rst_gnt", lsu_gnt_o, 1);
      tick();
      if_req_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
      chk("pre_rst_cnt", {dut.state_q, dut.starve_cnt_q}, {2'd2, 3'd1});
      rst_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h4444;
      @(negedge clk_i);
      chk("rst_rv", {lsu_rvalid_o, lsu_rdata_o}, 0);
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_rv", lsu_rvalid_o, 0);
      chk("post_rst_st", {dut.state_q, dut.starve_cnt_q}, 0);
      tick();
      mem_rvalid_i = 1'b0;
      tick();

      chk("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
